// File: rtl/gat_run_ctrl.sv
// gat_run_ctrl: sequences one GAT layer run on gat_top. It gates the three
// BRAM load-done flags, waits for a fresh gat_ready rising edge, then drains
// the new-feature BRAM through port B onto a valid/ready stream through a
// small credit-controlled FIFO.
module gat_run_ctrl #(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NEW_FEATURE_ADDR_W = 16,
  parameter int RD_LAT             = 2,
  parameter int FIFO_DEPTH         = 4,
  parameter int TIMEOUT_W          = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_start,
  input  logic                          cfg_abort,
  input  logic                          cfg_layer,
  input  logic [NEW_FEATURE_ADDR_W:0]   cfg_num_words,
  input  logic                          ld_h_data_done,
  input  logic                          ld_node_info_done,
  input  logic                          ld_wgt_done,
  output logic                          gat_layer,
  output logic                          h_data_bram_load_done,
  output logic                          h_node_info_bram_load_done,
  output logic                          wgt_bram_load_done,
  input  logic                          gat_ready,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]  m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          err_timeout,
  output logic [31:0]                   run_cycles
);

  localparam int AW    = NEW_FEATURE_ADDR_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = ~TIMEOUT_W'(1);

  typedef enum logic [2:0] {
    IDLE, WAIT_LOAD, RUN, WAIT_READY, DRAIN, DONE
  } state_t;

  state_t               state;
  logic                 load_done;
  logic [AW:0]          num_words_q;
  logic [AW:0]          issue_cnt;
  logic [AW:0]          xfer_cnt;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 armed;

  // read-return valid pipeline: vld_p[k] marks a read issued k cycles ago
  logic [RD_LAT:0]      vld_p;
  logic [CNT_W-1:0]     credit;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     fcnt;
  logic [NEW_FEATURE_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  logic issue;
  logic push;
  logic xfer;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign busy    = (state != IDLE);
  assign m_valid = (fcnt != '0);
  assign m_data  = m_valid ? fifo_mem[rd_ptr] : '0;
  assign xfer    = m_valid & m_ready;
  assign push    = vld_p[RD_LAT];
  assign issue   = (state == DRAIN) && (credit < CNT_W'(FIFO_DEPTH)) &&
                   (issue_cnt < num_words_q);

  assign h_data_bram_load_done      = load_done;
  assign h_node_info_bram_load_done = load_done;
  assign wgt_bram_load_done         = load_done;

  // Run sequencer: state, registered control outputs, address and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      gat_layer       <= 1'b0;
      load_done       <= 1'b0;
      done            <= 1'b0;
      err_timeout     <= 1'b0;
      run_cycles      <= '0;
      num_words_q     <= '0;
      issue_cnt       <= '0;
      xfer_cnt        <= '0;
      tmo_cnt         <= '0;
      armed           <= 1'b0;
      feat_bram_addrb <= '0;
    end else if (cfg_abort) begin
      state           <= IDLE;
      gat_layer       <= 1'b0;
      load_done       <= 1'b0;
      done            <= 1'b0;
      issue_cnt       <= '0;
      xfer_cnt        <= '0;
      tmo_cnt         <= '0;
      armed           <= 1'b0;
      feat_bram_addrb <= '0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && state != WAIT_LOAD) run_cycles <= sat_inc32(run_cycles);
      case (state)
        IDLE: begin
          if (cfg_start) begin
            state       <= WAIT_LOAD;
            gat_layer   <= cfg_layer;
            num_words_q <= cfg_num_words;
            err_timeout <= 1'b0;
            run_cycles  <= '0;
            issue_cnt   <= '0;
            xfer_cnt    <= '0;
          end
        end
        WAIT_LOAD: begin
          if (ld_h_data_done && ld_node_info_done && ld_wgt_done) begin
            state     <= RUN;
            load_done <= 1'b1;
          end
        end
        RUN: begin
          state   <= WAIT_READY;
          tmo_cnt <= '0;
          armed   <= 1'b0;
        end
        WAIT_READY: begin
          // only a low-then-high seen inside this state starts the drain
          if (armed && gat_ready) begin
            state     <= DRAIN;
            load_done <= 1'b0;
          end else if (tmo_cnt == TMO_LAST) begin
            state       <= IDLE;
            load_done   <= 1'b0;
            gat_layer   <= 1'b0;
            err_timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
            if (!gat_ready) armed <= 1'b1;
          end
        end
        DRAIN: begin
          if (issue) begin
            feat_bram_addrb <= {issue_cnt[AW-1:0], 2'b00};
            issue_cnt       <= issue_cnt + (AW+1)'(1);
          end
          if (xfer) begin
            xfer_cnt <= xfer_cnt + (AW+1)'(1);
            if (xfer_cnt == num_words_q - (AW+1)'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          gat_layer <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-return tracking and FIFO occupancy; abort discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p  <= '0;
      credit <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else if (cfg_abort) begin
      vld_p  <= '0;
      credit <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
    end else begin
      vld_p  <= {vld_p[RD_LAT-1:0], issue};
      credit <= credit + CNT_W'(issue) - CNT_W'(xfer);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (xfer) rd_ptr <= rd_ptr + PTR_W'(1);
      fcnt   <= fcnt + CNT_W'(push) - CNT_W'(xfer);
    end
  end

  // FIFO storage captures BRAM data when its read-return valid reaches the end
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= feat_bram_dout;
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (fcnt == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_gat_run_ctrl.sv
// Testbench for gat_run_ctrl: BRAM model, randomized stream backpressure and
// a word-index scoreboard derived from the run rules.
module tb_gat_run_ctrl;

  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int RDL = 2;
  localparam int TW  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start, cfg_abort, cfg_layer;
  logic [AW:0]   cfg_num_words;
  logic          ld_h, ld_node, ld_wgt;
  logic          gat_layer, h_ld, node_ld, wgt_ld;
  logic          gat_ready;
  logic [AW+1:0] feat_bram_addrb;
  logic [DW-1:0] feat_bram_dout;
  logic [DW-1:0] m_data;
  logic          m_valid, m_ready;
  logic          busy, done, err_timeout;
  logic [31:0]   run_cycles;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [31:0] seed = 32'h1234_5678;
  logic [DW-1:0] pipe [RDL];

  gat_run_ctrl #(
    .NEW_FEATURE_WIDTH(DW), .NEW_FEATURE_ADDR_W(AW), .RD_LAT(RDL),
    .FIFO_DEPTH(4), .TIMEOUT_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_layer(cfg_layer), .cfg_num_words(cfg_num_words),
    .ld_h_data_done(ld_h), .ld_node_info_done(ld_node), .ld_wgt_done(ld_wgt),
    .gat_layer(gat_layer), .h_data_bram_load_done(h_ld),
    .h_node_info_bram_load_done(node_ld), .wgt_bram_load_done(wgt_ld),
    .gat_ready(gat_ready), .feat_bram_addrb(feat_bram_addrb),
    .feat_bram_dout(feat_bram_dout), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .done(done), .err_timeout(err_timeout),
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_fn(input logic [31:0] idx);
    return (idx * 32'h9E37_79B1) ^ seed;
  endfunction

  // feature BRAM: content is a function of word index, RDL-cycle read latency
  always @(posedge clk) begin
    pipe[0] <= word_fn(32'(feat_bram_addrb[AW+1:2]));
    for (int i = 1; i < RDL; i++) pipe[i] <= pipe[i-1];
  end
  assign feat_bram_dout = pipe[RDL-1];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [2:0] ld_outs();
    return {h_ld, node_ld, wgt_ld};
  endfunction

  // ab_mode: 0 full run, 1 abort after ab_after words, 2 reset after ab_after words
  task automatic do_run(input int n, input bit layer, input int pct, input int rdy_delay,
                        input bit pre_high, input int late_ld, input bit poke,
                        input int ab_mode, input int ab_after);
    int t_run, t_done, t_ab, exp_idx, bud;
    bit prev_stall, bad_done;
    logic [DW-1:0] prev_data;
    seed = $urandom;
    ld_h = 1'b1; ld_node = 1'b1; ld_wgt = (late_ld == 0);
    gat_ready = pre_high;
    m_ready = 1'b0;
    cfg_layer = layer; cfg_num_words = (AW+1)'(n); cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    check_eq("start_busy", busy, 1);
    check_eq("start_layer", gat_layer, layer);
    check_eq("start_err_clr", err_timeout, 0);
    if (late_ld > 0) begin
      repeat (late_ld) step();
      check_eq("two_flags_hold", {busy, ld_outs()}, 4'b1000);
      ld_wgt = 1'b1;
    end
    step();
    check_eq("run_entry", ld_outs(), 3'b111);
    t_run = cyc;
    for (int j = 0; j < rdy_delay; j++) begin
      if (pre_high && j == rdy_delay - 3) gat_ready = 1'b0;
      step();
    end
    check_eq("no_early_drain", {ld_outs(), m_valid}, 4'b1110);
    step();
    gat_ready = 1'b1;
    check_eq("ld_before_edge", ld_outs(), 3'b111);
    step();
    gat_ready = 1'b0;
    check_eq("ld_drop", ld_outs(), 3'b000);
    exp_idx = 0; bud = 0; prev_stall = 0; bad_done = 0; prev_data = '0;
    while (exp_idx < n && !(ab_mode != 0 && exp_idx == ab_after) && bud < 40 * n + 200) begin
      if (prev_stall) begin
        check_eq("hold_valid", m_valid, 1);
        check_eq("hold_data", m_data, prev_data);
      end
      if (done) bad_done = 1;
      if (poke) begin
        cfg_start = (bud == 20);
        cfg_num_words = (AW+1)'(3);
      end
      m_ready = ($urandom_range(99) < pct);
      if (m_valid && m_ready) begin
        check_eq("data", m_data, word_fn(32'(exp_idx)));
        exp_idx++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      step();
      bud++;
    end
    cfg_start = 1'b0;
    m_ready = 1'b0;
    check_eq("early_done", bad_done, 0);
    if (ab_mode == 0) begin
      check_eq("words_out", exp_idx, n);
      check_eq("done_pulse", {done, busy, gat_layer}, {2'b11, layer});
      check_eq("last_addr", feat_bram_addrb, 64'((n - 1) * 4));
      t_done = cyc;
      step();
      check_eq("after_done", {done, busy, gat_layer, m_valid}, 4'b0000);
      check_eq("run_cycles", run_cycles, 64'(t_done - t_run + 1));
    end else begin
      repeat (6) step();
      check_eq("stall_valid", m_valid, 1);
      check_eq("stall_data", m_data, word_fn(32'(ab_after)));
      t_ab = cyc;
      if (ab_mode == 1) begin
        cfg_abort = 1'b1; cfg_start = 1'b1;
        step();
        cfg_abort = 1'b0; cfg_start = 1'b0;
        check_eq("abort_outs", {busy, m_valid, done, gat_layer, ld_outs()}, 7'b0);
        check_eq("abort_mdata", m_data, 0);
        check_eq("abort_runcyc", run_cycles, 64'(t_ab - t_run));
        repeat (4) step();
        check_eq("abort_flushed", {busy, m_valid}, 2'b00);
      end else begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_outs", {busy, m_valid, done, gat_layer, ld_outs(), err_timeout}, 8'b0);
        check_eq("rst_runcyc", run_cycles, 0);
        check_eq("rst_addr", feat_bram_addrb, 0);
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check_eq("rst_flushed", {busy, m_valid}, 2'b00);
      end
    end
  endtask

  task automatic do_timeout();
    int cnt, t_run;
    bit bad_done;
    gat_ready = 1'b0; ld_h = 1'b1; ld_node = 1'b1; ld_wgt = 1'b1;
    cfg_layer = 1'b1; cfg_num_words = (AW+1)'(4); cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    step();
    t_run = cyc;
    cnt = 0; bad_done = 0;
    while (ld_outs() == 3'b111 && cnt < 400) begin
      if (done) bad_done = 1;
      step();
      cnt++;
    end
    check_eq("tmo_len", cnt, (1 << TW));
    check_eq("tmo_state", {busy, err_timeout, done, gat_layer}, 4'b0100);
    check_eq("tmo_no_done", bad_done, 0);
    check_eq("tmo_runcyc", run_cycles, 64'(cyc - t_run));
    repeat (3) step();
    check_eq("tmo_sticky", err_timeout, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    cfg_start = 1'b0; cfg_abort = 1'b0; cfg_layer = 1'b0; cfg_num_words = '0;
    ld_h = 1'b0; ld_node = 1'b0; ld_wgt = 1'b0; gat_ready = 1'b0; m_ready = 1'b0;
    repeat (3) step();
    check_eq("reset_ctrl", {busy, m_valid, done, err_timeout, gat_layer, ld_outs()}, 8'b0);
    check_eq("reset_runcyc", run_cycles, 0);
    check_eq("reset_mdata", m_data, 0);
    rst_n = 1'b1;
    step();
    // abort together with start in IDLE leaves the block idle
    cfg_abort = 1'b1; cfg_start = 1'b1; cfg_num_words = (AW+1)'(4);
    step();
    cfg_abort = 1'b0; cfg_start = 1'b0;
    check_eq("abort_wins", busy, 0);

    do_run(8, 1'b1, 100, 50, 1'b0, 0, 1'b0, 0, 0);
    do_run(5, 1'b0, 100, 6, 1'b0, 10, 1'b0, 0, 0);
    do_run(6, 1'b1, 100, 20, 1'b1, 0, 1'b0, 0, 0);
    do_timeout();
    do_run(4, 1'b0, 100, 5, 1'b0, 0, 1'b0, 0, 0);
    do_run(3000, 1'b1, 50, 10, 1'b0, 0, 1'b1, 0, 0);
    do_run(8, 1'b1, 100, 5, 1'b0, 0, 1'b0, 1, 3);
    do_run(8, 1'b0, 100, 5, 1'b0, 0, 1'b0, 0, 0);
    do_run(8, 1'b1, 100, 5, 1'b0, 0, 1'b0, 2, 3);
    do_run(8, 1'b1, 70, 5, 1'b0, 0, 1'b0, 0, 0);
    for (int r = 0; r < 6; r++) begin
      do_run(int'($urandom_range(40, 1)), 1'($urandom_range(1)),
             int'($urandom_range(100, 20)), int'($urandom_range(20, 4)),
             1'b0, 0, 1'b0, 0, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
